// File: rtl/fft8_bf_sched.sv
// Sequencer for an 8-point radix-2 DIT FFT around an external butterfly unit.
// Define FFT8_INVERSE_EN to use the conjugate twiddle ROM (unscaled inverse DFT).
//
// state  | meaning
// LOAD   | accept 8 samples, store at bit-reversed addresses
// ISSUE  | one-cycle bf_start with operands and twiddle
// WAIT   | butterfly latency, down-counter to terminal count
// WRITE  | write bf_y1/bf_y2 back in place, advance butterfly/stage
// UNLOAD | stream X[0..7] in natural order
module fft8_bf_sched #(
  parameter int DW     = 16,
  parameter int BF_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_r_i,
  input  logic [DW-1:0] in_i_i,
  output logic          bf_start_o,
  output logic [DW-1:0] bf_x1_r_o,
  output logic [DW-1:0] bf_x1_i_o,
  output logic [DW-1:0] bf_x2_r_o,
  output logic [DW-1:0] bf_x2_i_o,
  output logic [DW-1:0] bf_w_r_o,
  output logic [DW-1:0] bf_w_i_o,
  input  logic [DW-1:0] bf_y1_r_i,
  input  logic [DW-1:0] bf_y1_i_i,
  input  logic [DW-1:0] bf_y2_r_i,
  input  logic [DW-1:0] bf_y2_i_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_r_o,
  output logic [DW-1:0] out_i_o,
  output logic          out_last_o,
  output logic          busy_o
);

  typedef enum logic [2:0] {S_LOAD, S_ISSUE, S_WAIT, S_WRITE, S_UNLOAD} state_t;

  localparam int WW    = (BF_LAT > 2) ? $clog2(BF_LAT) : 1;
  localparam int WLOAD = (BF_LAT > 1) ? BF_LAT - 2 : 0;

  localparam logic [DW-1:0] C_ZERO = '0;
  localparam logic [DW-1:0] C_ONE  = DW'(256);
  localparam logic [DW-1:0] C_MONE = DW'(-256);
  localparam logic [DW-1:0] C_R2   = DW'(181);
  localparam logic [DW-1:0] C_MR2  = DW'(-181);

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [1:0]      stage_q, stage_d;
  logic [1:0]      bfly_q, bfly_d;
  logic [WW-1:0]   wait_q, wait_d;

  logic [DW-1:0]   mem_r_q [8];
  logic [DW-1:0]   mem_i_q [8];
  logic [DW-1:0]   mem_r_d [8];
  logic [DW-1:0]   mem_i_d [8];

  logic            bf_start_q, bf_start_d;
  logic [DW-1:0]   bf_x1_r_q, bf_x1_r_d, bf_x1_i_q, bf_x1_i_d;
  logic [DW-1:0]   bf_x2_r_q, bf_x2_r_d, bf_x2_i_q, bf_x2_i_d;
  logic [DW-1:0]   bf_w_r_q, bf_w_r_d, bf_w_i_q, bf_w_i_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [DW-1:0]   out_r_q, out_r_d, out_i_q, out_i_d;

  logic [7:0]      a_cur, a_nxt;

  // Returns {i1, i2, k} for stage s, butterfly b.
  function automatic logic [7:0] bf_addr(input logic [1:0] s, input logic [1:0] b);
    logic [2:0] i1;
    logic [2:0] sp;
    logic [1:0] k;
    case (s)
      2'd0:    begin i1 = {b, 1'b0};           sp = 3'd1; k = 2'd0;       end
      2'd1:    begin i1 = {b[1], 1'b0, b[0]};  sp = 3'd2; k = {b[0], 1'b0}; end
      default: begin i1 = {1'b0, b};           sp = 3'd4; k = b;          end
    endcase
    return {i1, 3'(i1 + sp), k};
  endfunction

  function automatic logic [2*DW-1:0] twiddle(input logic [1:0] k);
    logic [2*DW-1:0] w;
    case (k)
`ifdef FFT8_INVERSE_EN
      2'd0:    w = {C_ONE,  C_ZERO};
      2'd1:    w = {C_R2,   C_R2};
      2'd2:    w = {C_ZERO, C_ONE};
      default: w = {C_MR2,  C_R2};
`else
      2'd0:    w = {C_ONE,  C_ZERO};
      2'd1:    w = {C_R2,   C_MR2};
      2'd2:    w = {C_ZERO, C_MONE};
      default: w = {C_MR2,  C_MR2};
`endif
    endcase
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    wait_d  = wait_q;
    mem_r_d = mem_r_q;
    mem_i_d = mem_i_q;
    a_cur   = bf_addr(stage_q, bfly_q);
    case (state_q)
      S_LOAD: begin
        if (in_valid_i) begin
          mem_r_d[{cnt_q[0], cnt_q[1], cnt_q[2]}] = in_r_i;
          mem_i_d[{cnt_q[0], cnt_q[1], cnt_q[2]}] = in_i_i;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = S_ISSUE;
            stage_d = 2'd0;
            bfly_d  = 2'd0;
          end
        end
      end
      S_ISSUE: begin
        if (BF_LAT > 1) begin
          state_d = S_WAIT;
          wait_d  = WW'(WLOAD);
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_WRITE;
        else              wait_d  = wait_q - 1'b1;
      end
      S_WRITE: begin
        mem_r_d[a_cur[7:5]] = bf_y1_r_i;
        mem_i_d[a_cur[7:5]] = bf_y1_i_i;
        mem_r_d[a_cur[4:2]] = bf_y2_r_i;
        mem_i_d[a_cur[4:2]] = bf_y2_i_i;
        if (stage_q == 2'd2 && bfly_q == 2'd3) begin
          state_d = S_UNLOAD;
          cnt_d   = 3'd0;
        end else begin
          state_d = S_ISSUE;
          bfly_d  = bfly_q + 2'd1;
          if (bfly_q == 2'd3) stage_d = stage_q + 2'd1;
        end
      end
      S_UNLOAD: begin
        if (out_ready_i) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Operands and output bins are read from the next-state memory image, so a
  // write-back landing on the same edge is always forwarded.
  always_comb begin
    bf_start_d  = 1'b0;
    bf_x1_r_d   = bf_x1_r_q;
    bf_x1_i_d   = bf_x1_i_q;
    bf_x2_r_d   = bf_x2_r_q;
    bf_x2_i_d   = bf_x2_i_q;
    bf_w_r_d    = bf_w_r_q;
    bf_w_i_d    = bf_w_i_q;
    a_nxt       = bf_addr(stage_d, bfly_d);
    if (state_d == S_ISSUE) begin
      bf_start_d             = 1'b1;
      bf_x1_r_d              = mem_r_d[a_nxt[7:5]];
      bf_x1_i_d              = mem_i_d[a_nxt[7:5]];
      bf_x2_r_d              = mem_r_d[a_nxt[4:2]];
      bf_x2_i_d              = mem_i_d[a_nxt[4:2]];
      {bf_w_r_d, bf_w_i_d}   = twiddle(a_nxt[1:0]);
    end
    out_valid_d = (state_d == S_UNLOAD);
    out_last_d  = out_valid_d && (cnt_d == 3'd7);
    out_r_d     = out_valid_d ? mem_r_d[cnt_d] : '0;
    out_i_d     = out_valid_d ? mem_i_d[cnt_d] : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      stage_q     <= '0;
      bfly_q      <= '0;
      wait_q      <= '0;
      bf_start_q  <= 1'b0;
      bf_x1_r_q   <= '0;
      bf_x1_i_q   <= '0;
      bf_x2_r_q   <= '0;
      bf_x2_i_q   <= '0;
      bf_w_r_q    <= '0;
      bf_w_i_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      bfly_q      <= bfly_d;
      wait_q      <= wait_d;
      bf_start_q  <= bf_start_d;
      bf_x1_r_q   <= bf_x1_r_d;
      bf_x1_i_q   <= bf_x1_i_d;
      bf_x2_r_q   <= bf_x2_r_d;
      bf_x2_i_q   <= bf_x2_i_d;
      bf_w_r_q    <= bf_w_r_d;
      bf_w_i_q    <= bf_w_i_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
    end
  end

  // Sample RAM deliberately has no reset.
  always_ff @(posedge clk_i) begin
    mem_r_q <= mem_r_d;
    mem_i_q <= mem_i_d;
  end

  assign in_ready_o  = (state_q == S_LOAD);
  assign busy_o      = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_WRITE);
  assign bf_start_o  = bf_start_q;
  assign bf_x1_r_o   = bf_x1_r_q;
  assign bf_x1_i_o   = bf_x1_i_q;
  assign bf_x2_r_o   = bf_x2_r_q;
  assign bf_x2_i_o   = bf_x2_i_q;
  assign bf_w_r_o    = bf_w_r_q;
  assign bf_w_i_o    = bf_w_i_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_r_o     = out_r_q;
  assign out_i_o     = out_i_q;

endmodule

// File: tb/tb_fft8_bf_sched.sv
// Directed bench for fft8_bf_sched with a behavioural Q8.8 butterfly of latency BF_LAT.
module tb_fft8_bf_sched;

  localparam int DW     = 16;
  localparam int BF_LAT = 3;

  typedef logic [15:0] vec8_t [8];

  localparam int EXP_SR [8] = '{256, 181, 0, -181, -256, -181, 0, 181};
  localparam int TW_R   [4] = '{256, 181, 0, -181};
`ifdef FFT8_INVERSE_EN
  localparam int EXP_SI [8] = '{0, 181, 256, 181, 0, -181, -256, -181};
  localparam int TW_I   [4] = '{0, 181, 256, 181};
`else
  localparam int EXP_SI [8] = '{0, -181, -256, -181, 0, 181, 256, 181};
  localparam int TW_I   [4] = '{0, -181, -256, -181};
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_r, in_i;
  logic          bf_start;
  logic [DW-1:0] bf_x1_r, bf_x1_i, bf_x2_r, bf_x2_i, bf_w_r, bf_w_i;
  logic [DW-1:0] bf_y1_r, bf_y1_i, bf_y2_r, bf_y2_i;
  logic          out_valid, out_ready, out_last, busy;
  logic [DW-1:0] out_r, out_i;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fft8_bf_sched #(.DW(DW), .BF_LAT(BF_LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_r_i(in_r), .in_i_i(in_i),
    .bf_start_o(bf_start),
    .bf_x1_r_o(bf_x1_r), .bf_x1_i_o(bf_x1_i), .bf_x2_r_o(bf_x2_r), .bf_x2_i_o(bf_x2_i),
    .bf_w_r_o(bf_w_r), .bf_w_i_o(bf_w_i),
    .bf_y1_r_i(bf_y1_r), .bf_y1_i_i(bf_y1_i), .bf_y2_r_i(bf_y2_r), .bf_y2_i_i(bf_y2_i),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_r_o(out_r), .out_i_o(out_i), .out_last_o(out_last), .busy_o(busy)
  );

  // Butterfly model: results are only valid exactly BF_LAT cycles after bf_start.
  int lat_cnt = 0;
  always @(posedge clk) begin
    if (bf_start === 1'b1)             lat_cnt <= 1;
    else if (lat_cnt > 0 && lat_cnt < 1000) lat_cnt <= lat_cnt + 1;
  end

  always_comb begin
    int wr, wi, x1r, x1i, x2r, x2i, pr, pi;
    wr  = int'($signed(bf_w_r));
    wi  = int'($signed(bf_w_i));
    x1r = int'($signed(bf_x1_r));
    x1i = int'($signed(bf_x1_i));
    x2r = int'($signed(bf_x2_r));
    x2i = int'($signed(bf_x2_i));
    pr  = (wr * x2r - wi * x2i) >>> 8;
    pi  = (wr * x2i + wi * x2r) >>> 8;
    bf_y1_r = (lat_cnt == BF_LAT) ? 16'(x1r + pr) : 16'hDEAD;
    bf_y1_i = (lat_cnt == BF_LAT) ? 16'(x1i + pi) : 16'hDEAD;
    bf_y2_r = (lat_cnt == BF_LAT) ? 16'(x1r - pr) : 16'hDEAD;
    bf_y2_i = (lat_cnt == BF_LAT) ? 16'(x1i - pi) : 16'hDEAD;
  end

  int          mon_n = 0;
  int          mon_cyc [256];
  logic [15:0] mon_x1 [256];
  logic [15:0] mon_x2 [256];
  logic [15:0] mon_wr [256];
  logic [15:0] mon_wi [256];
  always @(negedge clk) begin
    if (bf_start === 1'b1 && mon_n < 256) begin
      mon_cyc[mon_n] = cyc;
      mon_x1[mon_n]  = bf_x1_r;
      mon_x2[mon_n]  = bf_x2_r;
      mon_wr[mon_n]  = bf_w_r;
      mon_wi[mon_n]  = bf_w_i;
      mon_n++;
    end
  end

  task automatic send_frame(input vec8_t fr, input vec8_t fi);
    for (int n = 0; n < 8; n++) begin
      int t;
      t        = 0;
      in_valid = 1'b1;
      in_r     = fr[n];
      in_i     = fi[n];
      while (in_ready !== 1'b1 && t < 400) begin
        @(negedge clk);
        t++;
      end
      if (in_ready !== 1'b1) begin
        n_chk++; n_fail++;
        $display("FAIL send_timeout beat %0d: in_ready=%b required 1", n, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_r     = '0;
    in_i     = '0;
  endtask

  task automatic recv_frame(input int stall_at, output vec8_t rr, output vec8_t ri,
                            output logic [7:0] lst);
    for (int m = 0; m < 8; m++) begin
      int t;
      t = 0;
      while (out_valid !== 1'b1 && t < 400) begin
        @(negedge clk);
        t++;
      end
      if (out_valid !== 1'b1) begin
        n_chk++; n_fail++;
        $display("FAIL recv_timeout beat %0d: out_valid=%b required 1", m, out_valid);
      end
      rr[m]  = out_r;
      ri[m]  = out_i;
      lst[m] = out_last;
      if (m == stall_at) begin
        repeat (5) begin
          @(negedge clk);
          n_chk++;
          if (out_valid !== 1'b1 || out_r !== rr[m] || out_i !== ri[m] || out_last !== lst[m]) begin
            n_fail++;
            $display("FAIL stall_hold beat %0d: got v=%b (%0h,%0h) last=%b required v=1 (%0h,%0h) last=%b",
                     m, out_valid, out_r, out_i, out_last, rr[m], ri[m], lst[m]);
          end
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_r = '0; in_i = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || bf_start !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rdy=%b ov=%b last=%b start=%b busy=%b required 1 0 0 0 0",
               in_ready, out_valid, out_last, bf_start, busy);
    end
    n_chk++;
    if ({bf_x1_r, bf_x1_i, bf_x2_r, bf_x2_i, bf_w_r, bf_w_i, out_r, out_i} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: x1=%h/%h x2=%h/%h w=%h/%h out=%h/%h required all 0",
               bf_x1_r, bf_x1_i, bf_x2_r, bf_x2_i, bf_w_r, bf_w_i, out_r, out_i);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_impulse_result(input string nm);
    vec8_t fr, fi, rr, ri;
    logic [7:0] lst;
    for (int n = 0; n < 8; n++) begin fr[n] = '0; fi[n] = '0; end
    fr[0] = 16'd256;
    send_frame(fr, fi);
    recv_frame(-1, rr, ri, lst);
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (rr[k] !== 16'd256 || ri[k] !== 16'd0) begin
        n_fail++;
        $display("FAIL %s_bin%0d: got (%0d,%0d) required (256,0)", nm, k, $signed(rr[k]), $signed(ri[k]));
      end
      n_chk++;
      if (lst[k] !== (k == 7)) begin
        n_fail++;
        $display("FAIL %s_last%0d: got %b required %b", nm, k, lst[k], (k == 7));
      end
    end
  endtask

  task automatic test_impulse();
    check_impulse_result("impulse");
  endtask

  task automatic test_dc();
    vec8_t fr, fi, rr, ri;
    logic [7:0] lst;
    for (int n = 0; n < 8; n++) begin fr[n] = 16'd256; fi[n] = '0; end
    send_frame(fr, fi);
    recv_frame(-1, rr, ri, lst);
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (rr[k] !== ((k == 0) ? 16'd2048 : 16'd0) || ri[k] !== 16'd0) begin
        n_fail++;
        $display("FAIL dc_bin%0d: got (%0d,%0d) required (%0d,0)", k, $signed(rr[k]), $signed(ri[k]),
                 (k == 0) ? 2048 : 0);
      end
    end
  endtask

  task automatic shifted_impulse(input string nm, input int stall_at, input bit poke_in);
    vec8_t fr, fi, rr, ri;
    logic [7:0] lst;
    for (int n = 0; n < 8; n++) begin fr[n] = '0; fi[n] = '0; end
    fr[1] = 16'd256;
    send_frame(fr, fi);
    if (poke_in) begin
      for (int p = 0; p < 6; p++) begin
        in_valid = 1'b1; in_r = 16'h7777; in_i = 16'h5555;
        n_chk++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_ignore%0d: in_ready=%b busy=%b required 0 1", nm, p, in_ready, busy);
        end
        @(negedge clk);
      end
      in_valid = 1'b0; in_r = '0; in_i = '0;
    end
    recv_frame(stall_at, rr, ri, lst);
    for (int k = 0; k < 8; k++) begin
      int dr, di;
      dr = int'($signed(rr[k])) - EXP_SR[k];
      di = int'($signed(ri[k])) - EXP_SI[k];
      n_chk++;
      if (dr > 1 || dr < -1 || di > 1 || di < -1 || lst[k] !== (k == 7)) begin
        n_fail++;
        $display("FAIL %s_bin%0d: got (%0d,%0d) last=%b required (%0d,%0d) last=%b", nm, k,
                 $signed(rr[k]), $signed(ri[k]), lst[k], EXP_SR[k], EXP_SI[k], (k == 7));
      end
    end
  endtask

  task automatic test_shifted_impulse();
    shifted_impulse("shift", -1, 1'b0);
  endtask

  task automatic test_backpressure();
    shifted_impulse("bp", 3, 1'b1);
  endtask

  task automatic test_schedule();
    vec8_t fr, fi, rr, ri;
    logic [7:0] lst;
    int base;
    int e1 [4] = '{1, 3, 2, 4};
    int e2 [4] = '{5, 7, 6, 8};
    int k1 [4] = '{0, 2, 0, 2};
    base = mon_n;
    for (int n = 0; n < 8; n++) begin fr[n] = 16'(n + 1); fi[n] = '0; end
    send_frame(fr, fi);
    recv_frame(-1, rr, ri, lst);
    n_chk++;
    if (mon_n - base !== 12) begin
      n_fail++;
      $display("FAIL sched_count: got %0d starts required 12", mon_n - base);
    end
    for (int j = 1; j < 12; j++) begin
      n_chk++;
      if (mon_cyc[base + j] - mon_cyc[base + j - 1] !== BF_LAT + 1) begin
        n_fail++;
        $display("FAIL sched_gap%0d: got %0d cycles required %0d", j,
                 mon_cyc[base + j] - mon_cyc[base + j - 1], BF_LAT + 1);
      end
    end
    for (int b = 0; b < 4; b++) begin
      n_chk++;
      if (mon_x1[base + b] !== 16'(e1[b]) || mon_x2[base + b] !== 16'(e2[b])) begin
        n_fail++;
        $display("FAIL sched_s0b%0d: got x1=%0d x2=%0d required x1=%0d x2=%0d", b,
                 mon_x1[base + b], mon_x2[base + b], e1[b], e2[b]);
      end
      n_chk++;
      if (mon_wr[base + 4 + b] !== 16'(TW_R[k1[b]]) || mon_wi[base + 4 + b] !== 16'(TW_I[k1[b]])) begin
        n_fail++;
        $display("FAIL sched_s1w%0d: got (%0d,%0d) required (%0d,%0d)", b,
                 $signed(mon_wr[base + 4 + b]), $signed(mon_wi[base + 4 + b]), TW_R[k1[b]], TW_I[k1[b]]);
      end
      n_chk++;
      if (mon_wr[base + 8 + b] !== 16'(TW_R[b]) || mon_wi[base + 8 + b] !== 16'(TW_I[b])) begin
        n_fail++;
        $display("FAIL sched_s2w%0d: got (%0d,%0d) required (%0d,%0d)", b,
                 $signed(mon_wr[base + 8 + b]), $signed(mon_wi[base + 8 + b]), TW_R[b], TW_I[b]);
      end
    end
    n_chk++;
    if (rr[0] !== 16'd36 || ri[0] !== 16'd0) begin
      n_fail++;
      $display("FAIL sched_x0: got (%0d,%0d) required (36,0)", $signed(rr[0]), $signed(ri[0]));
    end
  endtask

  task automatic test_reset_mid();
    vec8_t fr, fi;
    int base, t;
    base = mon_n;
    for (int n = 0; n < 8; n++) begin fr[n] = 16'(3 * n + 7); fi[n] = 16'(n); end
    send_frame(fr, fi);
    t = 0;
    while (mon_n - base < 5 && t < 400) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (mon_n - base < 5) begin
      n_fail++;
      $display("FAIL rstmid_reach: got %0d starts required 5", mon_n - base);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || bf_start !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: rdy=%b ov=%b busy=%b start=%b required 1 0 0 0",
               in_ready, out_valid, busy, bf_start);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: rdy=%b ov=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
    end
    check_impulse_result("rstmid");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_shifted_impulse();
    test_schedule();
    test_backpressure();
    test_reset_mid();
    test_impulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
